// File: rtl/cla256_bits.sv
// 4-ary hierarchical carry-lookahead adder with registered operands and results,
// plus a behavioural reference sum that flags and counts any lookahead disagreement.
module cla256_bits #(
  parameter int N    = 256,
  parameter int TYPE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         prop,
  output logic         gen,
  output logic         out_valid,
  output logic         mismatch,
  output logic [31:0]  err_count
);

  localparam int L = $clog2(N) / 2;

  // Returns {G, P} of a 4-wide group.
  function automatic logic [1:0] grp4(input logic [3:0] p, input logic [3:0] g);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  // Carry into each of the four children, flattened so no carry ripples through another.
  function automatic logic [3:0] carry4(input logic [3:0] p, input logic [3:0] g, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [N-1:0] r_a, r_b;
  logic         r_cin, r_v1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
      r_v1  <= 1'b0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_cin <= cin;
      end
    end
  end

  logic [N-1:0] w_p0, w_g0, w_c0;
  assign w_p0 = r_a ^ r_b;
  assign w_g0 = r_a & r_b;

  // Level l holds N/4^l groups: P/G flow up from children, carries flow down to them.
  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int W = N >> (2 * l);
    logic [4*W-1:0] w_kp, w_kg, w_kc;
    logic [W-1:0]   w_p, w_g, w_c;

    if (l == 1) begin : g_leaf
      assign w_kp = w_p0;
      assign w_kg = w_g0;
    end else begin : g_node
      assign w_kp = g_lvl[l-1].w_p;
      assign w_kg = g_lvl[l-1].w_g;
    end

    if (l == L) begin : g_root
      assign w_c = {W{r_cin}};
    end else begin : g_inner
      assign w_c = g_lvl[l+1].w_kc;
    end

    // NOTE: combinational outputs get a default before the loop so no path can infer a latch.
    always_comb begin
      w_p = '0;
      w_g = '0;
      for (int j = 0; j < W; j++) begin
        {w_g[j], w_p[j]} = grp4(w_kp[4*j +: 4], w_kg[4*j +: 4]);
      end
    end

    always_comb begin
      w_kc = '0;
      for (int j = 0; j < W; j++) begin
        w_kc[4*j +: 4] = carry4(w_kp[4*j +: 4], w_kg[4*j +: 4], w_c[j]);
      end
    end
  end

  assign w_c0 = g_lvl[1].w_kc;

  logic [N-1:0] w_sum;
  logic         w_p_top, w_g_top, w_cout;
  assign w_sum   = w_p0 ^ w_c0;
  assign w_p_top = g_lvl[L].w_p[0];
  assign w_g_top = g_lvl[L].w_g[0];
  assign w_cout  = w_g_top | (w_p_top & r_cin);

  // Behavioural reference; a+b is kept separately because its carry is the reference gen.
  logic [N:0] w_ref_ab, w_ref;
  logic       w_prop_ref, w_type_chk, w_mis;
  assign w_ref_ab   = {1'b0, r_a} + {1'b0, r_b};
  assign w_ref      = w_ref_ab + {{N{1'b0}}, r_cin};
  assign w_prop_ref = &(r_a ^ r_b);
  assign w_type_chk = (TYPE != 0);
  assign w_mis = (w_sum != w_ref[N-1:0]) | (w_cout != w_ref[N])
               | (w_type_chk & ((w_p_top != w_prop_ref) | (w_g_top != w_ref_ab[N])));

  logic [N-1:0] r_s;
  logic         r_cout, r_prop, r_gen, r_out_valid, r_mismatch;
  logic [31:0]  r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_prop      <= 1'b0;
      r_gen       <= 1'b0;
      r_out_valid <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      r_mismatch  <= r_v1 & w_mis;
      if (r_v1) begin
        r_s    <= w_sum;
        r_cout <= w_cout;
        r_prop <= w_p_top;
        r_gen  <= w_g_top;
      end
    end
  end

  // Saturating count of flagged results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= '0;
    end else if (r_out_valid && r_mismatch && (r_err != 32'hFFFF_FFFF)) begin
      r_err <= r_err + 32'd1;
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign prop      = r_prop;
  assign gen       = r_gen;
  assign out_valid = r_out_valid;
  assign mismatch  = r_mismatch;
  assign err_count = r_err;

endmodule

// File: tb/tb_cla256_bits.sv
// Random and directed stimulus for cla256_bits, run on TYPE=1 and TYPE=0 instances side by side
// and checked against an arithmetic model of the two-stage pipeline.
module tb_cla256_bits;

  localparam int N = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         cin = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;

  logic [N-1:0] s1, s0;
  logic         cout1, cout0, prop1, prop0, gen1, gen0;
  logic         ov1, ov0, mis1, mis0;
  logic [31:0]  err1, err0;

  always #5 clk = ~clk;

  cla256_bits #(.N(N), .TYPE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cin(cin), .a(a), .b(b),
    .s(s1), .cout(cout1), .prop(prop1), .gen(gen1),
    .out_valid(ov1), .mismatch(mis1), .err_count(err1)
  );

  cla256_bits #(.N(N), .TYPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cin(cin), .a(a), .b(b),
    .s(s0), .cout(cout0), .prop(prop0), .gen(gen0),
    .out_valid(ov0), .mismatch(mis0), .err_count(err0)
  );

  int checks = 0;
  int failures = 0;

  // Model: what the output stage should show now, and what was captured at the last edge.
  logic         exp_v, pend_v;
  logic [N-1:0] exp_s, pend_s;
  logic         exp_cout, exp_prop, exp_gen, pend_cout, pend_prop, pend_gen;

  task automatic check(input string tag, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid_t1", ov1, exp_v);
    check("out_valid_t0", ov0, exp_v);
    check("s_t1", s1, exp_s);
    check("s_t0", s0, exp_s);
    check("cout_t1", cout1, exp_cout);
    check("cout_t0", cout0, exp_cout);
    check("prop_t1", prop1, exp_prop);
    check("gen_t1", gen1, exp_gen);
    check("prop_t0", prop0, exp_prop);
    check("gen_t0", gen0, exp_gen);
    check("mismatch_t1", mis1, 1'b0);
    check("mismatch_t0", mis0, 1'b0);
    check("err_count_t1", err1, 32'd0);
    check("err_count_t0", err0, 32'd0);
  endtask

  task automatic step(input logic v, input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc);
    logic [N:0] full, ab;
    in_valid = v;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    @(posedge clk);
    #1;
    exp_v = pend_v;
    if (pend_v) begin
      exp_s    = pend_s;
      exp_cout = pend_cout;
      exp_prop = pend_prop;
      exp_gen  = pend_gen;
    end
    check_outputs();
    pend_v = v;
    if (v) begin
      ab        = {1'b0, ta} + {1'b0, tb_v};
      full      = ab + {{N{1'b0}}, tc};
      pend_s    = full[N-1:0];
      pend_cout = full[N];
      pend_prop = &(ta ^ tb_v);
      pend_gen  = ab[N];
    end
  endtask

  task automatic clear_model();
    exp_v = 1'b0; exp_s = '0; exp_cout = 1'b0; exp_prop = 1'b0; exp_gen = 1'b0;
    pend_v = 1'b0; pend_s = '0; pend_cout = 1'b0; pend_prop = 1'b0; pend_gen = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    for (int i = 0; i < N / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  logic [N-1:0] ones, zero, msb, ones_lsb0, ra, rb, bit1;
  int           mode;

  initial begin
    ones      = '1;
    zero      = '0;
    msb       = '0;
    msb[N-1]  = 1'b1;
    ones_lsb0 = ones;
    ones_lsb0[0] = 1'b0;
    clear_model();

    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // all-ones + 0 + 1 wraps to zero with a pure propagate chain
    step(1'b1, ones, zero, 1'b1);
    step(1'b0, zero, zero, 1'b0);
    check("dir1_s", s1, zero);
    check("dir1_cout", cout1, 1'b1);
    check("dir1_prop", prop1, 1'b1);
    check("dir1_gen", gen1, 1'b0);

    step(1'b1, ones, ones, 1'b0);
    step(1'b0, zero, zero, 1'b0);
    check("dir2_s", s1, ones_lsb0);
    check("dir2_cout", cout1, 1'b1);
    check("dir2_prop", prop1, 1'b0);
    check("dir2_gen", gen1, 1'b1);

    // back-to-back pair
    step(1'b1, N'(5), N'(3), 1'b0);
    step(1'b1, msb, msb, 1'b1);
    check("dir3a_valid", ov1, 1'b1);
    check("dir3a_s", s1, N'(8));
    check("dir3a_cout", cout1, 1'b0);
    step(1'b0, zero, zero, 1'b0);
    check("dir3b_valid", ov1, 1'b1);
    check("dir3b_s", s1, N'(1));
    check("dir3b_cout", cout1, 1'b1);
    check("dir3b_gen", gen1, 1'b1);
    step(1'b0, zero, zero, 1'b0);

    for (int i = 0; i < 30000; i++) begin
      ra   = rand_word();
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: rb = rand_word();
        1: rb = ~ra;
        2: begin
          bit1 = '0;
          bit1[$urandom_range(0, N-1)] = 1'b1;
          rb = ~ra ^ bit1;
        end
        default: begin
          ra = ($urandom_range(0, 1) != 0) ? ones : zero;
          rb = rand_word();
        end
      endcase
      step(1'b1, ra, rb, 1'($urandom_range(0, 1)));
      check("prop_gen_excl", prop1 & gen1, 1'b0);
    end
    step(1'b0, zero, zero, 1'b0);
    step(1'b0, zero, zero, 1'b0);

    // reset with two results in flight
    step(1'b1, rand_word(), rand_word(), 1'b1);
    step(1'b1, ones, N'(1), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, zero, zero, 1'b0);
    step(1'b0, zero, zero, 1'b0);
    step(1'b1, rand_word(), rand_word(), 1'b1);
    step(1'b0, zero, zero, 1'b0);
    check("post_reset_valid", ov1, 1'b1);
    step(1'b0, zero, zero, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
